// File: rtl/wave_osc_pkg.sv
// wave_osc_pkg: waveform encodings, default widths and the quarter-sine table generator.
package wave_osc_pkg;
    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_e;
    localparam int DEF_PHASE_W = 16;
    localparam int DEF_LUT_AW  = 6;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_AMP_W   = 8;
    // Taylor series keeps table generation to plain real arithmetic at elaboration
    function automatic int sine_entry(input int idx, input int aw, input int mw);
        real x, term, s;
        x = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(2 ** aw);
        term = x;
        s = x;
        for (int k = 1; k < 10; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s = s + term;
        end
        return $rtoi(real'((2 ** mw) - 1) * s + 0.5);
    endfunction
endpackage

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: combinational first-quadrant sine magnitudes sampled at bin centres.
module sine_quarter_rom
    import wave_osc_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int MAG_W  = DEF_OUT_W - 1
) (
    input  logic [LUT_AW-1:0] addr,
    output logic [MAG_W-1:0]  mag
);
    logic [MAG_W-1:0] rom [2**LUT_AW];
    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam int V = sine_entry(i, LUT_AW, MAG_W);
        assign rom[i] = MAG_W'(V);
    end
    assign mag = rom[addr];
endmodule

// File: rtl/wave_osc.sv
// wave_osc: phase-accumulator oscillator with quarter-wave sine ROM, four waveforms,
// amplitude scaling and a three-stage pipeline from tick to signed/split outputs.
module wave_osc
    import wave_osc_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int AMP_W   = DEF_AMP_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] fcw,
    input  logic               phase_clr,
    input  logic [1:0]         wave_sel,
    input  logic [AMP_W-1:0]   amplitude,
    output logic [OUT_W-1:0]   sample_out,
    output logic [OUT_W-2:0]   pos_out,
    output logic [OUT_W-2:0]   neg_out,
    output logic               sample_valid,
    output logic               wrap
);
    localparam int P  = PHASE_W;
    localparam int M  = OUT_W - 1;
    localparam int PW = M + AMP_W + 1;
    logic [P-1:0] phase;
    logic [P:0] sum;
    logic tick;
    wave_e wave0;
    logic [AMP_W-1:0] amp0, amp1;
    logic v0, v1, v2, c0, c1, c2, s1, s2;
    logic [M-1:0] mag_c, mag1, mag2, rom_mag;
    logic [LUT_AW-1:0] idx;
    logic [PW-1:0] prod;
    assign tick = enable & sample_tick;
    assign sum  = {1'b0, phase} + {1'b0, fcw};
    assign idx  = phase[P-2] ? ~phase[P-3 -: LUT_AW] : phase[P-3 -: LUT_AW];
    sine_quarter_rom #(.LUT_AW(LUT_AW), .MAG_W(M)) u_rom (.addr(idx), .mag(rom_mag));
    always_comb begin
        mag_c = wave0 == WAVE_SINE   ? rom_mag :
                wave0 == WAVE_SQUARE ? {M{1'b1}} :
                wave0 == WAVE_SAW    ? (phase[P-1] ? ~phase[P-2 -: M] : phase[P-2 -: M]) :
                                       (phase[P-2] ? ~phase[P-3 -: M] : phase[P-3 -: M]);
    end
    // (amplitude+1) makes all-ones exactly unity after the >> AMP_W
    assign prod = PW'(mag1) * (PW'(amp1) + PW'(1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
            wave0 <= WAVE_SINE;
            amp0 <= '0;
            amp1 <= '0;
            {v0, v1, v2, c0, c1, c2, s1, s2} <= '0;
            mag1 <= '0;
            mag2 <= '0;
            sample_out <= '0;
            pos_out <= '0;
            neg_out <= '0;
            sample_valid <= 1'b0;
            wrap <= 1'b0;
        end else begin
            v0 <= tick;
            if (phase_clr) phase <= '0;
            else if (tick) phase <= sum[P-1:0];
            if (tick) begin
                wave0 <= wave_e'(wave_sel);
                amp0 <= amplitude;
                c0 <= sum[P] & ~phase_clr;
            end
            v1 <= v0;
            s1 <= phase[P-1];
            mag1 <= mag_c;
            amp1 <= amp0;
            c1 <= c0;
            v2 <= v1;
            s2 <= s1;
            mag2 <= M'(prod >> AMP_W);
            c2 <= c1;
            sample_valid <= v2;
            wrap <= v2 & c2;
            if (v2) begin
                sample_out <= s2 ? -{1'b0, mag2} : {1'b0, mag2};
                pos_out <= s2 ? '0 : mag2;
                neg_out <= s2 ? mag2 : '0;
            end
        end
    end
endmodule

// File: tb/tb_wave_osc.sv
// tb_wave_osc: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_wave_osc;
    typedef struct packed {
        logic signed [7:0] s;
        logic [6:0]        p;
        logic [6:0]        n;
        logic              w;
        logic [31:0]       c;
    } samp_t;
    localparam real PI = 3.14159265358979;
    logic clk = 0, reset_n = 0, enable = 0, sample_tick = 0, phase_clr = 0;
    logic [15:0] fcw = 0;
    logic [1:0] wave_sel = 0;
    logic [7:0] amplitude = 0;
    logic [7:0] sample_out;
    logic [6:0] pos_out, neg_out;
    logic sample_valid, wrap;
    int tests = 0, fails = 0, cyc = 0, m_phase = 0;
    bit m_wrap = 0;
    samp_t obs_q[$], exp_q[$];

    wave_osc dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_tick(sample_tick),
        .fcw(fcw), .phase_clr(phase_clr), .wave_sel(wave_sel), .amplitude(amplitude),
        .sample_out(sample_out), .pos_out(pos_out), .neg_out(neg_out),
        .sample_valid(sample_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (sample_valid) obs_q.push_back({sample_out, pos_out, neg_out, wrap, 32'(cyc)});
    end

    // Expected sample straight from the waveform definitions; c is the edge the strobe should appear on.
    function automatic samp_t ref_samp(input int ph, input int w, input int amp, input bit wr, input int c);
        samp_t r;
        int mag, idx;
        bit neg;
        neg = ph >= 32768;
        idx = (ph / 256) % 64;
        if ((ph / 16384) % 2 == 1) idx = 63 - idx;
        if (w == 0) mag = $rtoi(127.0 * $sin(PI / 2.0 * (idx + 0.5) / 64.0) + 0.5);
        else if (w == 1) mag = 127;
        else if (w == 2) mag = neg ? 127 - (ph / 256) % 128 : (ph / 256) % 128;
        else mag = (ph / 16384) % 2 == 1 ? 127 - (ph / 128) % 128 : (ph / 128) % 128;
        mag = mag * (amp + 1) / 256;
        r.s = 8'(neg ? -mag : mag);
        r.p = 7'(neg ? 0 : mag);
        r.n = 7'(neg ? mag : 0);
        r.w = wr;
        r.c = 32'(c);
        return r;
    endfunction

    task automatic step(input bit en, input bit tk, input bit clr, input int w, input int a, input int f);
        enable = en;
        sample_tick = tk;
        phase_clr = clr;
        wave_sel = 2'(w);
        amplitude = 8'(a);
        fcw = 16'(f);
        if (clr) begin
            m_phase = 0;
            m_wrap = 0;
        end else if (en && tk) begin
            m_wrap = (m_phase + (f % 65536)) > 65535;
            m_phase = (m_phase + (f % 65536)) % 65536;
        end
        if (en && tk) exp_q.push_back(ref_samp(m_phase, w, a, m_wrap, cyc + 4));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        enable = 0;
        sample_tick = 0;
        phase_clr = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic restart;
        step(0, 0, 1, 0, 0, 0);
        idle(1);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset_n = 0;
        enable = 1;
        sample_tick = 1;
        fcw = 16'h1111;
        repeat (3) @(negedge clk);
        tests++;
        if (sample_out !== 0 || pos_out !== 0 || neg_out !== 0) begin
            fails++;
            $display("FAIL reset_outputs got %0d/%0d/%0d want 0/0/0", sample_out, pos_out, neg_out);
        end
        tests++;
        if (sample_valid !== 0 || wrap !== 0) begin
            fails++;
            $display("FAIL reset_strobes got valid=%b wrap=%b want 0/0", sample_valid, wrap);
        end
        idle(0);
        reset_n = 1;
        m_phase = 0;
        idle(2);
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_no_samples got %0d want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_sine;
        int t0, nw;
        t0 = cyc + 1;
        step(1, 1, 0, 0, 8'hFF, 16'h0400);
        idle(5);
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL sine_first_count got %0d want 1", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].s != 14 || obs_q[0].p != 14 || obs_q[0].n != 0) begin
                fails++;
                $display("FAIL sine_first got s=%0d p=%0d n=%0d want 14/14/0", obs_q[0].s, obs_q[0].p, obs_q[0].n);
            end
            tests++;
            if (int'(obs_q[0].c) - t0 != 3) begin
                fails++;
                $display("FAIL sine_latency got %0d want 3", int'(obs_q[0].c) - t0);
            end
        end
        for (int i = 0; i < 63; i++) step(1, 1, 0, 0, 8'hFF, 16'h0400);
        idle(5);
        nw = 0;
        foreach (obs_q[i]) nw += int'(obs_q[i].w);
        tests++;
        if (nw != 1) begin
            fails++;
            $display("FAIL sine_wrap_count got %0d want 1", nw);
        end
        tests++;
        if (obs_q.size() != 64) begin
            fails++;
            $display("FAIL sine_count got %0d want 64", obs_q.size());
        end else begin
            tests++;
            if (obs_q[63].w !== 1 || obs_q[63].s != 2) begin
                fails++;
                $display("FAIL sine_wrap_sample got s=%0d w=%b want s=2 w=1", obs_q[63].s, obs_q[63].w);
            end
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL sine[%0d] got s=%0d w=%b cyc=%0d (%h) want s=%0d w=%b cyc=%0d (%h)", i,
                         obs_q[i].s, obs_q[i].w, obs_q[i].c, obs_q[i], exp_q[i].s, exp_q[i].w, exp_q[i].c, exp_q[i]);
            end
        end
    endtask

    task automatic test_triangle;
        int ws[4] = '{127, 0, -127, 0};
        restart();
        repeat (4) step(1, 1, 0, 3, 8'hFF, 16'h4000);
        idle(5);
        tests++;
        if (obs_q.size() != 4) begin
            fails++;
            $display("FAIL tri_count got %0d want 4", obs_q.size());
        end else begin
            foreach (ws[i]) begin
                tests++;
                if (obs_q[i].s != ws[i] || obs_q[i].w !== (i == 3)) begin
                    fails++;
                    $display("FAIL tri[%0d] got s=%0d w=%b want s=%0d w=%0d", i, obs_q[i].s, obs_q[i].w, ws[i], i == 3);
                end
            end
            tests++;
            if (obs_q[2].n != 127 || obs_q[2].p != 0) begin
                fails++;
                $display("FAIL tri_neg got p=%0d n=%0d want 0/127", obs_q[2].p, obs_q[2].n);
            end
        end
    endtask

    task automatic test_square_gain;
        restart();
        repeat (16) step(1, 1, 0, 1, 8'hFF, 16'h0800);
        repeat (16) step(1, 1, 0, 1, 8'h7F, 16'h0800);
        idle(5);
        tests++;
        if (obs_q.size() != 32) begin
            fails++;
            $display("FAIL square_count got %0d want 32", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].s != 127 || obs_q[15].s != -127 || obs_q[16].s != -63 || obs_q[31].s != 63) begin
                fails++;
                $display("FAIL square_levels got %0d %0d %0d %0d want 127 -127 -63 63",
                         obs_q[0].s, obs_q[15].s, obs_q[16].s, obs_q[31].s);
            end
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL square[%0d] got s=%0d w=%b cyc=%0d (%h) want s=%0d w=%b cyc=%0d (%h)", i,
                         obs_q[i].s, obs_q[i].w, obs_q[i].c, obs_q[i], exp_q[i].s, exp_q[i].w, exp_q[i].c, exp_q[i]);
            end
        end
    endtask

    task automatic test_saw;
        restart();
        repeat (2) step(1, 1, 0, 2, 8'hFF, 16'h8000);
        idle(5);
        tests++;
        if (obs_q.size() != 2) begin
            fails++;
            $display("FAIL saw_count got %0d want 2", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].s != -127 || obs_q[0].n != 127 || obs_q[0].w !== 0) begin
                fails++;
                $display("FAIL saw_first got s=%0d n=%0d w=%b want -127/127/0", obs_q[0].s, obs_q[0].n, obs_q[0].w);
            end
            tests++;
            if (obs_q[1].s != 0 || obs_q[1].p != 0 || obs_q[1].n != 0 || obs_q[1].w !== 1) begin
                fails++;
                $display("FAIL saw_second got s=%0d p=%0d n=%0d w=%b want 0/0/0/1",
                         obs_q[1].s, obs_q[1].p, obs_q[1].n, obs_q[1].w);
            end
        end
    endtask

    task automatic test_back_to_back;
        samp_t last;
        restart();
        repeat (10) step(1, 1, 0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(1, 65535));
        repeat (5) step(0, 1, 0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(1, 65535));
        idle(6);
        tests++;
        if (obs_q.size() != 10) begin
            fails++;
            $display("FAIL b2b_count got %0d want 10", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL b2b[%0d] got s=%0d w=%b cyc=%0d (%h) want s=%0d w=%b cyc=%0d (%h)", i,
                         obs_q[i].s, obs_q[i].w, obs_q[i].c, obs_q[i], exp_q[i].s, exp_q[i].w, exp_q[i].c, exp_q[i]);
            end
        end
        last = exp_q[$];
        tests++;
        if (sample_out !== last.s || pos_out !== last.p || neg_out !== last.n || sample_valid !== 0) begin
            fails++;
            $display("FAIL b2b_hold got s=%0d p=%0d n=%0d v=%b want s=%0d p=%0d n=%0d v=0",
                     $signed(sample_out), pos_out, neg_out, sample_valid, last.s, last.p, last.n);
        end
        obs_q.delete();
        exp_q.delete();
        step(1, 1, 1, 1, 8'hFF, 16'h1234);
        idle(5);
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL clr_count got %0d want 1", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0].s != 127 || obs_q[0].w !== 0 || obs_q[0] !== exp_q[0]) begin
                fails++;
                $display("FAIL clr_tick got s=%0d w=%b (%h) want s=127 w=0 (%h)", obs_q[0].s, obs_q[0].w, obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_midflight;
        restart();
        repeat (2) step(1, 1, 0, 3, 8'hFF, 16'h2468);
        reset_n = 0;
        #1;
        tests++;
        if (sample_out !== 0 || pos_out !== 0 || neg_out !== 0 || sample_valid !== 0 || wrap !== 0) begin
            fails++;
            $display("FAIL midreset_outputs got s=%0d p=%0d n=%0d v=%b w=%b want all 0",
                     sample_out, pos_out, neg_out, sample_valid, wrap);
        end
        @(negedge clk);
        reset_n = 1;
        m_phase = 0;
        exp_q.delete();
        idle(6);
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL midreset_drop got %0d samples want 0", obs_q.size());
        end
        obs_q.delete();
        step(1, 1, 0, 2, 8'hFF, 16'h2468);
        idle(5);
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL midreset_next_count got %0d want 1", obs_q.size());
        end else begin
            tests++;
            if (obs_q[0] !== exp_q[0]) begin
                fails++;
                $display("FAIL midreset_next got s=%0d (%h) want s=%0d (%h)", obs_q[0].s, obs_q[0], exp_q[0].s, exp_q[0]);
            end
        end
    endtask

    task automatic test_random;
        restart();
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 3) == 0 ? 16'hC000 : $urandom_range(0, 65535));
        idle(6);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL random[%0d] got s=%0d w=%b cyc=%0d (%h) want s=%0d w=%b cyc=%0d (%h)", i,
                         obs_q[i].s, obs_q[i].w, obs_q[i].c, obs_q[i], exp_q[i].s, exp_q[i].w, exp_q[i].c, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sine();
        test_triangle();
        test_square_gain();
        test_saw();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
